// File: rtl/alu.sv
// alu: N-bit arithmetic/logic unit with registered result and NZCV flags.
// The result and flags are computed combinationally from the current operands
// and opcode, then captured on every rising clock edge. Latency is 1 cycle.
module alu #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] a_num,
    input  logic [N-1:0] b_num,
    input  logic [2:0]   ALUControl,
    output logic [N-1:0] ALUResult,
    output logic [3:0]   ALUFlags
);

    localparam int SW = $clog2(N);

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_LSL = 3'b101,
        OP_LSR = 3'b110,
        OP_ASR = 3'b111
    } alu_op_e;

    alu_op_e       op;
    logic [SW-1:0] shamt;
    logic [N:0]    sum_add;
    logic [N:0]    sum_sub;
    logic [N-1:0]  res;
    logic          flag_n;
    logic          flag_z;
    logic          flag_c;
    logic          flag_v;

    assign op    = alu_op_e'(ALUControl);
    // Only the low log2(N) bits of b select the shift distance.
    assign shamt = b_num[SW-1:0];

    // N+1-bit sums so the carry out of bit N-1 lands in bit N.
    assign sum_add = {1'b0, a_num} + {1'b0, b_num};
    assign sum_sub = {1'b0, a_num} + {1'b0, ~b_num} + {{N{1'b0}}, 1'b1};

    // Select the result and the op-dependent carry/overflow flags.
    always_comb begin
        res    = '0;
        flag_c = 1'b0;
        flag_v = 1'b0;
        case (op)
            OP_ADD: begin
                res    = sum_add[N-1:0];
                flag_c = sum_add[N];
                flag_v = (a_num[N-1] == b_num[N-1]) && (sum_add[N-1] != a_num[N-1]);
            end
            OP_SUB: begin
                res    = sum_sub[N-1:0];
                flag_c = sum_sub[N];
                flag_v = (a_num[N-1] != b_num[N-1]) && (sum_sub[N-1] != a_num[N-1]);
            end
            OP_AND: res = a_num & b_num;
            OP_OR:  res = a_num | b_num;
            OP_XOR: res = a_num ^ b_num;
            OP_LSL: res = a_num << shamt;
            OP_LSR: res = a_num >> shamt;
            OP_ASR: res = $unsigned($signed(a_num) >>> shamt);
            default: res = '0;
        endcase
    end

    assign flag_n = res[N-1];
    assign flag_z = (res == '0);

    // Output registers: capture result and flags every edge; async clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ALUResult <= '0;
            ALUFlags  <= '0;
        end else begin
            ALUResult <= res;
            ALUFlags  <= {flag_n, flag_z, flag_c, flag_v};
        end
    end

endmodule

// File: tb/tb_alu.sv
// tb_alu: directed-vector self-checking bench for the alu (N = 32).
module tb_alu;

    logic        clk;
    logic        rst_n;
    logic [31:0] a_num;
    logic [31:0] b_num;
    logic [2:0]  ALUControl;
    logic [31:0] ALUResult;
    logic [3:0]  ALUFlags;

    int unsigned n_checks;
    int unsigned n_errors;

    typedef struct {
        string       tag;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        logic [31:0] res;
        logic [3:0]  flags;
    } vec_t;

    vec_t vecs[$];

    alu #(.N(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .a_num      (a_num),
        .b_num      (b_num),
        .ALUControl (ALUControl),
        .ALUResult  (ALUResult),
        .ALUFlags   (ALUFlags)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Drive one vector, let one edge capture it, sample 1 time unit later.
    task automatic run_vec(input vec_t v);
        a_num      = v.a;
        b_num      = v.b;
        ALUControl = v.op;
        @(posedge clk);
        #1;
        check({v.tag, ".res"}, ALUResult, v.res);
        check({v.tag, ".flags"}, {28'd0, ALUFlags}, {28'd0, v.flags});
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;

        // Reset held with operands present: outputs stay cleared across edges.
        rst_n      = 1'b0;
        a_num      = 32'd5;
        b_num      = 32'd3;
        ALUControl = 3'b000;
        repeat (2) @(posedge clk);
        #1;
        check("rst.res", ALUResult, 32'd0);
        check("rst.flags", {28'd0, ALUFlags}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_release.res", ALUResult, 32'd8);

        // Directed vectors, applied back to back (one per cycle).
        vecs.push_back('{"add_basic",  32'd1,        32'd10,       3'b000, 32'd11,       4'b0000});
        vecs.push_back('{"sub_eq",     32'd10,       32'd10,       3'b001, 32'd0,        4'b0110});
        vecs.push_back('{"sub_neg",    32'd1,        32'd10,       3'b001, 32'hFFFFFFF7, 4'b1000});
        vecs.push_back('{"sub_pos",    32'd5,        32'd3,        3'b001, 32'd2,        4'b0010});
        vecs.push_back('{"and_same",   32'd10,       32'd10,       3'b010, 32'd10,       4'b0000});
        vecs.push_back('{"or_same",    32'd10,       32'd10,       3'b011, 32'd10,       4'b0000});
        vecs.push_back('{"xor_same",   32'd10,       32'd10,       3'b100, 32'd0,        4'b0100});
        vecs.push_back('{"and_mask",   32'hF0F0F0F0, 32'h0FF00FF0, 3'b010, 32'h00F000F0, 4'b0000});
        vecs.push_back('{"add_ovf",    32'h7FFFFFFF, 32'd1,        3'b000, 32'h80000000, 4'b1001});
        vecs.push_back('{"add_carry",  32'hFFFFFFFF, 32'd1,        3'b000, 32'd0,        4'b0110});
        vecs.push_back('{"sub_ovf",    32'h80000000, 32'd1,        3'b001, 32'h7FFFFFFF, 4'b0011});
        vecs.push_back('{"lsl4",       32'h80000001, 32'd4,        3'b101, 32'h00000010, 4'b0000});
        vecs.push_back('{"lsr4",       32'h80000001, 32'd4,        3'b110, 32'h08000000, 4'b0000});
        vecs.push_back('{"asr4",       32'h80000001, 32'd4,        3'b111, 32'hF8000000, 4'b1000});
        vecs.push_back('{"asr4_pos",   32'h40000000, 32'd4,        3'b111, 32'h04000000, 4'b0000});
        vecs.push_back('{"lsl32",      32'h80000001, 32'd32,       3'b101, 32'h80000001, 4'b1000});
        vecs.push_back('{"lsr32",      32'h80000001, 32'd32,       3'b110, 32'h80000001, 4'b1000});
        vecs.push_back('{"asr32",      32'h80000001, 32'd32,       3'b111, 32'h80000001, 4'b1000});
        vecs.push_back('{"lsl36",      32'h80000001, 32'd36,       3'b101, 32'h00000010, 4'b0000});
        // Pipelined sweep over all 8 opcodes with fresh operands every cycle.
        vecs.push_back('{"pipe_add",   32'h12345678, 32'h11111111, 3'b000, 32'h23456789, 4'b0000});
        vecs.push_back('{"pipe_sub",   32'd3,        32'd5,        3'b001, 32'hFFFFFFFE, 4'b1000});
        vecs.push_back('{"pipe_and",   32'hFF00FF00, 32'h0F0F0F0F, 3'b010, 32'h0F000F00, 4'b0000});
        vecs.push_back('{"pipe_or",    32'hFF00FF00, 32'h0F0F0F0F, 3'b011, 32'hFF0FFF0F, 4'b1000});
        vecs.push_back('{"pipe_xor",   32'hFF00FF00, 32'h0F0F0F0F, 3'b100, 32'hF00FF00F, 4'b1000});
        vecs.push_back('{"pipe_lsl",   32'd1,        32'd31,       3'b101, 32'h80000000, 4'b1000});
        vecs.push_back('{"pipe_lsr",   32'h80000000, 32'd31,       3'b110, 32'd1,        4'b0000});
        vecs.push_back('{"pipe_asr",   32'h80000000, 32'd31,       3'b111, 32'hFFFFFFFF, 4'b1000});
        foreach (vecs[i]) run_vec(vecs[i]);

        // Inputs changing between edges must not disturb the registered output.
        #1;
        a_num      = 32'd100;
        b_num      = 32'd200;
        ALUControl = 3'b000;
        #2;
        check("hold.res", ALUResult, 32'hFFFFFFFF);
        check("hold.flags", {28'd0, ALUFlags}, 32'h8);

        // Asynchronous reset between edges clears outputs immediately.
        run_vec('{"pre_rst", 32'd7, 32'd9, 3'b000, 32'd16, 4'b0000});
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst.res", ALUResult, 32'd0);
        check("async_rst.flags", {28'd0, ALUFlags}, 32'd0);
        @(posedge clk);
        #1;
        check("rst_hold.res", ALUResult, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_vec('{"post_rst", 32'd7, 32'd9, 3'b000, 32'd16, 4'b0000});

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
